// File: rtl/servant_uart_tx.sv
// Wishbone-slave 8N1 UART transmitter (LSB first) with a small TX FIFO.
// The servant mux generates the bus ack; this slave only acts on the first cycle of each access.
module servant_uart_tx #(
  parameter logic [15:0] DEFAULT_DIV = 16'd868,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_cyc,
  output logic [31:0] o_wb_rdt,
  output logic        o_tx
);

  localparam int AW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic        cyc_q;
  logic        strobe;
  logic        wr_data;
  logic        wr_div;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        push_ok;
  logic        pop;
  logic [7:0]  head;

  logic [15:0] divisor;
  logic [15:0] eff_div;
  logic [15:0] bit_len;
  logic [15:0] baud_cnt;
  logic        bit_done;

  logic [1:0]  state;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        tx_q;
  logic        busy;

  logic        unused_dat;

  assign unused_dat = ^i_wb_dat[30:16];

  // The mux holds cyc for two cycles; only the rising edge of cyc has an effect.
  assign strobe  = i_wb_cyc & ~cyc_q;
  assign wr_data = strobe & i_wb_we & ~i_wb_adr;
  assign wr_div  = strobe & i_wb_we & i_wb_adr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  assign eff_div  = (divisor == 16'd0) ? 16'd1 : divisor;
  assign bit_done = (baud_cnt == bit_len - 16'd1);

  // Pop from IDLE immediately, or in the last stop cycle so frames run back to back.
  assign pop     = ~empty & ((state == S_IDLE) | ((state == S_STOP) & bit_done));
  assign push_ok = wr_data & (~full | pop);

  assign busy = (state != S_IDLE);
  assign o_tx = tx_q;

  always_comb begin
    o_wb_rdt = 32'd0;
    if (i_wb_adr) begin
      o_wb_rdt = {16'd0, divisor};
    end else begin
      o_wb_rdt = {28'd0, overflow, full, empty, busy};
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= i_wb_dat[7:0];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cyc_q    <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
      divisor  <= DEFAULT_DIV;
    end else begin
      cyc_q <= i_wb_cyc;
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (wr_data && full && !pop) begin
        overflow <= 1'b1;
      end else if (wr_div && i_wb_dat[31]) begin
        overflow <= 1'b0;
      end
      if (wr_div) begin
        divisor <= i_wb_dat[15:0];
      end
    end
  end

  // tx_q is loaded with the level of the upcoming bit at each bit boundary.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= S_IDLE;
      bit_idx  <= 3'd0;
      baud_cnt <= 16'd0;
      bit_len  <= 16'd1;
      shreg    <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shreg    <= head;
            bit_len  <= eff_div;
            baud_cnt <= 16'd0;
            tx_q     <= 1'b0;
            state    <= S_START;
          end
        end
        S_START: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            bit_idx  <= 3'd0;
            tx_q     <= shreg[0];
            state    <= S_DATA;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            shreg    <= {1'b0, shreg[7:1]};
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx_q    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            baud_cnt <= 16'd0;
            if (pop) begin
              shreg   <= head;
              bit_len <= eff_div;
              tx_q    <= 1'b0;
              state   <= S_START;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/servant_uart_tx.md
Name: servant_uart_tx

Overview:
- Wishbone-slave UART transmitter (8N1, LSB first) with a small TX FIFO.
- Sits downstream of servant_mux as a further peripheral slot, next to the GPIO and timer slaves; drives a board UART TX pin.
- Follows the servant peripheral model: the mux generates the ack, so the slave has no ack output.
- Read data is combinational; every bus access completes in the mux's fixed ack time.

Parameters:
- DEFAULT_DIV, 16'd868, reset value of the baud divisor (clock cycles per bit; 868 = 115200 baud at 100 MHz).
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of 2, 2..64.

Ports:
- i_clk  input  1  system clock (wb_clk).
- i_rst  input  1  reset, asynchronous, active-high (wb_rst).
- i_wb_adr  input  1  register select (CPU address bit 2).
- i_wb_dat  input  32  write data.
- i_wb_we  input  1  write enable.
- i_wb_cyc  input  1  cycle/select from servant_mux.
- o_wb_rdt  output  32  read data, combinational from i_wb_adr.
- o_tx  output  1  serial output, idle high.

Behaviour:
Reset and clocking:
- Single clock. Reset is asynchronous and active-high.
- On reset: o_tx=1, FIFO empty (rd/wr pointers 0), overflow=0, divisor=DEFAULT_DIV, FSM=IDLE, bit counter 0, baud counter 0, cyc_q=0.
- Reset mid-frame aborts the frame immediately; o_tx goes high asynchronously.

Access strobe:
- The mux holds i_wb_cyc high for 2 cycles per access.
- cyc_q is i_wb_cyc registered. An access acts only when i_wb_cyc & !cyc_q, so each access produces exactly one side effect.

Register map:
- adr=0, write: push i_wb_dat[7:0] into the FIFO.
- adr=0, read: {28'b0, overflow, full, empty, busy}.
  - busy = FSM != IDLE.
  - empty and full reflect the FIFO state.
- adr=1, write: divisor <= i_wb_dat[15:0]. If i_wb_dat[31]=1, also clear overflow.
- adr=1, read: {16'b0, divisor}.

FIFO:
- Pointers are log2(FIFO_DEPTH)+1 bits wide. full when MSBs differ and the rest are equal; empty when all bits are equal.
- Push while full and no pop in the same cycle: data is dropped and overflow is set (sticky).
- Push while full with a pop in the same cycle: push is accepted and overflow is unchanged.
- Push and pop in the same cycle while empty cannot occur, because pop requires !empty.

Divisor:
- A divisor of 0 is treated as 1.
- The divisor is latched into bit_len at frame start (the pop cycle). Writes mid-frame affect the next frame only.

FSM (IDLE, START, DATA, STOP):
- IDLE: if !empty, pop the head into shreg, load bit_len, baud counter = 0, go to START. The pop happens in the same cycle empty is seen.
- START: o_tx=0 for bit_len cycles, then go to DATA with bit index 0.
- DATA: o_tx=shreg[0] for bit_len cycles per bit, shifting right after each bit. After bit 7, go to STOP.
- STOP: o_tx=1 for bit_len cycles. In the last STOP cycle:
  - if !empty, pop and go directly to START (no idle gap);
  - otherwise go to IDLE.

Timing:
- o_tx is registered. The first push into an idle, empty UART drives o_tx low 2 cycles after the push cycle: cycle+1 pop, cycle+2 low.
- Frame length is exactly 10*bit_len cycles. Back-to-back frames are contiguous.

Test Plan:
- Reset with divisor 4; push 0xA5 at adr 0 -> o_tx low 2 cycles after push, then serial bits 1,0,1,0,0,1,0,1 at 4 cycles each, high stop for 4; busy=1 during the frame; status reads 0x2 afterwards.
- Push 3 bytes back-to-back with divisor 2 -> three contiguous 20-cycle frames with no idle gap; empty rises at the third pop; busy drops exactly 60 cycles after the first start bit.
- With divisor 100, push 9 bytes (FIFO_DEPTH=8) -> first byte is popped, all 8 remaining accepted, full=1, no overflow. Push a 10th byte -> dropped, status bit3=1. Write adr1 with 0x8000_0064 -> overflow=0, divisor unchanged at 100.
- Hold i_wb_cyc and i_wb_we for 2 cycles with a single push of 0x3C -> exactly one entry enqueued and exactly one frame transmitted.
- Write divisor 8 mid-frame while divisor is 4 -> current frame finishes at 4 cycles/bit; next queued frame uses 8. Writing divisor 0 gives 1 cycle/bit.
- Assert i_rst mid-DATA -> o_tx=1 immediately without waiting for a clock; status reads 0x2; adr1 reads DEFAULT_DIV.
